// File: rtl/mem_org_switch_ctrl.sv
// rtl/mem_org_switch_ctrl.sv - memory-organization switch controller with drain/settle/commit sequencing
//
// Purpose: accepts a new memory-organization mode over a two-register CSR slave,
// stalls the kernel memory path, waits for outstanding requests to drain, waits a
// quiet settle window and then commits the new mode to the kernel/host conduits.
//
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   slave_address                0 = mode register, 1 = status register
//   slave_writedata/readdata     CSR data (read data is combinational)
//   slave_read, slave_write      CSR strobes
//   slave_waitrequest            holds a mode write while a switch is running
//   mem_req_issue, mem_rsp_done  one pulse per memory request issued / completed
//   mem_stall                    blocks new kernel memory requests during a switch
//   mem_organization_kernel/host committed mode (identical)
//   switch_busy                  controller is not idle
//
// Build option: define MEM_ORG_SWITCH_TIMEOUT_EN to enable the drain timeout and
// the sticky timeout_err status bit.

module mem_org_switch_ctrl #(
    parameter int WIDTH          = 32,
    parameter int CONDUIT_WIDTH  = 2,
    parameter int CNT_WIDTH      = 8,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     slave_address,
    input  logic [WIDTH-1:0]         slave_writedata,
    input  logic                     slave_read,
    input  logic                     slave_write,
    output logic [WIDTH-1:0]         slave_readdata,
    output logic                     slave_waitrequest,
    input  logic                     mem_req_issue,
    input  logic                     mem_rsp_done,
    output logic                     mem_stall,
    output logic [CONDUIT_WIDTH-1:0] mem_organization_kernel,
    output logic [CONDUIT_WIDTH-1:0] mem_organization_host,
    output logic                     switch_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_SETTLE,
        S_COMMIT
    } state_t;

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0]        SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;

    state_t                   r_state;
    logic [CONDUIT_WIDTH-1:0] r_mode;
    logic [CONDUIT_WIDTH-1:0] r_pending;
    logic [CNT_WIDTH-1:0]     r_outstanding;
    logic [15:0]              r_switch_cnt;
    logic [SW-1:0]            r_settle_cnt;

    logic                     w_idle;
    logic                     w_mode_change;
    logic                     w_timeout_err;
    logic [31:0]              w_status;
    logic                     w_unused_ok;

`ifdef MEM_ORG_SWITCH_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_drain_timer;
    logic          r_timeout_err;

    assign w_timeout_err = r_timeout_err;
`else
    assign w_timeout_err = 1'b0;
`endif

    assign w_idle        = (r_state == S_IDLE);
    // Writing the already-committed mode is a no-op and never starts a switch.
    assign w_mode_change = slave_write & ~slave_address & w_idle &
                           (slave_writedata[CONDUIT_WIDTH-1:0] != r_mode);

    assign mem_stall               = ~w_idle;
    assign switch_busy             = ~w_idle;
    assign slave_waitrequest       = slave_write & ~slave_address & ~w_idle;
    assign mem_organization_kernel = r_mode;
    assign mem_organization_host   = r_mode;

    // Only the mode field and the timeout-clear bit of the write data matter.
    assign w_unused_ok = &{1'b0, slave_writedata};

    // Outstanding-request counter; saturates high, ignores a completion at zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_outstanding <= '0;
        end else begin
            case ({mem_req_issue, mem_rsp_done})
                2'b10: if (r_outstanding != CNT_MAX) r_outstanding <= r_outstanding + 1'b1;
                2'b01: if (r_outstanding != '0)      r_outstanding <= r_outstanding - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_mode       <= '0;
            r_pending    <= '0;
            r_switch_cnt <= '0;
            r_settle_cnt <= '0;
`ifdef MEM_ORG_SWITCH_TIMEOUT_EN
            r_drain_timer <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
`ifdef MEM_ORG_SWITCH_TIMEOUT_EN
            // Placed before the FSM so a timeout in the same cycle wins over a clear.
            if (slave_write & slave_address & slave_writedata[1]) begin
                r_timeout_err <= 1'b0;
            end
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_mode_change) begin
                        r_pending <= slave_writedata[CONDUIT_WIDTH-1:0];
                        r_state   <= S_DRAIN;
`ifdef MEM_ORG_SWITCH_TIMEOUT_EN
                        r_drain_timer <= '0;
`endif
                    end
                end
                S_DRAIN: begin
                    if (r_outstanding == '0) begin
                        r_state      <= S_SETTLE;
                        r_settle_cnt <= '0;
                    end
`ifdef MEM_ORG_SWITCH_TIMEOUT_EN
                    else if (r_drain_timer == TIMEOUT_LAST) begin
                        // Abort: committed mode and switch counter stay as they were.
                        r_state       <= S_IDLE;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_drain_timer <= r_drain_timer + 1'b1;
                    end
`endif
                end
                S_SETTLE: begin
                    if (r_outstanding != '0) begin
                        // A request slipped through the stall; drain again.
                        r_state <= S_DRAIN;
`ifdef MEM_ORG_SWITCH_TIMEOUT_EN
                        r_drain_timer <= '0;
`endif
                    end else if (r_settle_cnt == SETTLE_LAST) begin
                        r_state <= S_COMMIT;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end
                S_COMMIT: begin
                    r_mode       <= r_pending;
                    r_switch_cnt <= r_switch_cnt + 16'd1;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_status         = '0;
        w_status[0]      = ~w_idle;
        w_status[1]      = w_timeout_err;
        w_status[15:8]   = 8'(r_outstanding);
        w_status[31:16]  = r_switch_cnt;
        slave_readdata   = '0;
        if (slave_read) begin
            slave_readdata = slave_address ? WIDTH'(w_status) : WIDTH'(r_mode);
        end
    end

endmodule
